// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Lock supervisor and reset sequencer for an ECP5 EHXPLLL.
//                Pulses the PLL reset and waits for a synchronized LOCK. It
//                releases the system reset only after lock has held for
//                STABLE_CYCLES. A lock timeout re-arms the PLL, and a loss of
//                lock re-asserts the system reset. Both events are counted in
//                saturating debug counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int STABLE_CYCLES    = 1024,
  parameter int CNT_W            = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0]    C_PULSE_END    = CW'(RST_PULSE_CYCLES);
  localparam logic [CW-1:0]    C_TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    C_STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    C_CNT_ONE      = CW'(1);
  localparam logic [CNT_W-1:0] C_EVT_MAX      = '1;
  localparam logic [CNT_W-1:0] C_EVT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             locked_ff1_q, locked_s_q;
  logic             pll_rst_q, sys_reset_q, ready_q;
  logic [CNT_W-1:0] loss_q, timeout_q;
  logic             loss_inc, timeout_inc;

  // Two-flop synchronizer for the asynchronous PLL LOCK output.
  always_ff @(posedge clock) begin
    if (reset) begin
      locked_ff1_q <= 1'b0;
      locked_s_q   <= 1'b0;
    end else begin
      locked_ff1_q <= locked;
      locked_s_q   <= locked_ff1_q;
    end
  end

  // Next-state logic and the shared phase counter.
  // A pulse entered from reset counts from 0, so the cycles spent under
  // reset do not shorten it. A pulse entered from a timeout counts its
  // entry cycle as the first pulse cycle. Either way the pulse lasts
  // RST_PULSE_CYCLES cycles after it starts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + C_CNT_ONE;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == C_PULSE_END) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d     = ST_PLL_RESET;
          cnt_d       = C_CNT_ONE;
          timeout_inc = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == C_STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s_q) begin
          state_d  = ST_WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. The outputs are registered from the next state, so
  // sys_reset moves on the same edge as the transition that causes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == ST_PLL_RESET);
      sys_reset_q <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  // Saturating event counters. A clear wins over a coincident increment.
  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      loss_q    <= '0;
      timeout_q <= '0;
    end else begin
      if (loss_inc && (loss_q != C_EVT_MAX)) begin
        loss_q <= loss_q + C_EVT_ONE;
      end
      if (timeout_inc && (timeout_q != C_EVT_MAX)) begin
        timeout_q <= timeout_q + C_EVT_ONE;
      end
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset     = sys_reset_q;
  assign ready         = ready_q;
  assign loss_count    = loss_q;
  assign timeout_count = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_supervisor
//  Description : Self-checking bench for pll_lock_supervisor. A deadline-based
//                reference model predicts every output on every cycle.
//                Directed checks cover the documented timing points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int RST  = 4;
  localparam int TO   = 100;
  localparam int ST   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  localparam int PH_PLLRST = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STAB   = 2;
  localparam int PH_RUN    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          locked = 1'b0;
  logic          clear_counts = 1'b0;
  logic          pll_rst, sys_reset, ready;
  logic [CW-1:0] loss_count, timeout_count;
  logic [10:0]   obs;

  int errors = 0;
  int checks = 0;

  // Reference model state: phase plus the absolute edge index at which it ends.
  int n = 0;
  int m_phase = PH_PLLRST;
  int pr_end = 0, wl_deadline = 0, st_done = 0;
  int m_loss = 0, m_to = 0;
  bit s1 = 1'b0, s2 = 1'b0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RST),
    .TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES(ST),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .locked(locked),
    .clear_counts(clear_counts),
    .pll_rst(pll_rst),
    .sys_reset(sys_reset),
    .ready(ready),
    .loss_count(loss_count),
    .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  assign obs = {pll_rst, sys_reset, ready, loss_count, timeout_count};

  // Advance the model by the effect of one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit lk, input bit clr);
    bit ls;
    n++;
    if (r) begin
      m_phase = PH_PLLRST;
      pr_end  = n + RST + 1;
      m_loss  = 0;
      m_to    = 0;
      s1      = 1'b0;
      s2      = 1'b0;
    end else begin
      ls = s2;
      s2 = s1;
      s1 = lk;
      case (m_phase)
        PH_PLLRST: if (n == pr_end) begin m_phase = PH_WAIT; wl_deadline = n + TO; end
        PH_WAIT: begin
          if (ls) begin
            m_phase = PH_STAB; st_done = n + ST;
          end else if (n == wl_deadline) begin
            m_phase = PH_PLLRST; pr_end = n + RST;
            if (m_to < CMAX) m_to++;
          end
        end
        PH_STAB: begin
          if (!ls) begin m_phase = PH_WAIT; wl_deadline = n + TO; end
          else if (n == st_done) m_phase = PH_RUN;
        end
        default: begin
          if (!ls) begin
            m_phase = PH_WAIT; wl_deadline = n + TO;
            if (m_loss < CMAX) m_loss++;
          end
        end
      endcase
      if (clr) begin m_loss = 0; m_to = 0; end
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [10:0] v;
    v = {(m_phase == PH_PLLRST), (m_phase != PH_RUN), (m_phase == PH_RUN), 4'(m_loss), 4'(m_to)};
    return v;
  endfunction

  // Drive inputs (we sit just after a falling edge), take one rising edge, return at the next falling edge.
  task automatic cyc(input bit r, input bit lk, input bit clr);
    reset        = r;
    locked       = lk;
    clear_counts = clr;
    model_step(r, lk, clr);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    logic exp_p;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if ({pll_rst, sys_reset, ready} !== 3'b110 || loss_count !== 4'd0 || timeout_count !== 4'd0) begin
        errors++;
        $display("FAIL reset_state: pll_rst=%b sys_reset=%b ready=%b loss=%0d timeout=%0d, want 1 1 0 0 0",
                 pll_rst, sys_reset, ready, loss_count, timeout_count);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      exp_p = (k <= RST);
      checks++;
      if (pll_rst !== exp_p || sys_reset !== 1'b1) begin
        errors++;
        $display("FAIL reset_pulse edge+%0d: pll_rst=%b sys_reset=%b, want %b 1", k, pll_rst, sys_reset, exp_p);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_reset edge %0d: got %b want %b", n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_lock_acquire;
    int e;
    logic exp_sr;
    for (int k = 9; k <= 20; k++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    e = n;
    for (int d = 0; d <= 14; d++) begin
      if (d > 0) cyc(1'b0, 1'b1, 1'b0);
      exp_sr = (d < ST + 2);
      checks++;
      if (sys_reset !== exp_sr || ready !== !exp_sr) begin
        errors++;
        $display("FAIL lock_acquire E+%0d: sys_reset=%b ready=%b, want %b %b", n - e, sys_reset, ready, exp_sr, !exp_sr);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_acquire edge %0d: got %b want %b", n, obs, exp_vec());
      end
    end
    checks++;
    if (loss_count !== 4'd0 || timeout_count !== 4'd0) begin
      errors++;
      $display("FAIL acquire_counts: loss=%0d timeout=%0d, want 0 0", loss_count, timeout_count);
    end
  endtask

  task automatic test_lock_loss;
    int dd;
    logic exp_sr;
    for (int d = 0; d < 20; d++) begin
      cyc(1'b0, (d >= 3), 1'b0);
      if (d == 0) dd = n;
      exp_sr = ((n - dd) >= 2) && ((n - dd) < 13);
      checks++;
      if (sys_reset !== exp_sr || pll_rst !== 1'b0) begin
        errors++;
        $display("FAIL lock_loss D+%0d: sys_reset=%b pll_rst=%b, want %b 0", n - dd, sys_reset, pll_rst, exp_sr);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_loss edge %0d: got %b want %b", n, obs, exp_vec());
      end
    end
    checks++;
    if (loss_count !== 4'd1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_count: loss=%0d ready=%b, want 1 1", loss_count, ready);
    end
  endtask

  task automatic test_timeout;
    int x;
    int rises;
    logic prev;
    rises = 0;
    prev  = pll_rst;
    for (int i = 0; i < 1800; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (i == 0) x = n;
      if (pll_rst && !prev) begin
        checks++;
        if (n !== x + 102 + 104 * rises) begin
          errors++;
          $display("FAIL timeout_pulse_start #%0d: edge X+%0d, want X+%0d", rises, n - x, 102 + 104 * rises);
        end
        rises++;
      end
      prev = pll_rst;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_timeout edge %0d: got %b want %b", n, obs, exp_vec());
      end
      if (i == 499) begin
        checks++;
        if (timeout_count !== 4'd4 || rises !== 4) begin
          errors++;
          $display("FAIL timeout_count_500: count=%0d pulses=%0d, want 4 4", timeout_count, rises);
        end
      end
    end
    checks++;
    if (timeout_count !== 4'd15 || rises !== 17) begin
      errors++;
      $display("FAIL timeout_saturate: count=%0d pulses=%0d, want 15 17", timeout_count, rises);
    end
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (timeout_count !== 4'd0 || loss_count !== 4'd0) begin
      errors++;
      $display("FAIL clear_counts: timeout=%0d loss=%0d, want 0 0", timeout_count, loss_count);
    end
  endtask

  task automatic test_stabilize_toggle;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, ((i / 5) % 2) == 1, 1'b0);
      checks++;
      if (sys_reset !== 1'b1 || ready !== 1'b0 || loss_count !== 4'd0) begin
        errors++;
        $display("FAIL toggle_no_run cycle %0d: sys_reset=%b ready=%b loss=%0d, want 1 0 0", i, sys_reset, ready, loss_count);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_toggle edge %0d: got %b want %b", n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clear_on_loss;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup_run: ready=%b, want 1", ready);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (loss_count !== 4'd1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_first_loss: loss=%0d ready=%b, want 1 1", loss_count, ready);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (loss_count !== 4'd0 || sys_reset !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_loss: loss=%0d sys_reset=%b, want 0 1", loss_count, sys_reset);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || loss_count !== 4'd0) begin
      errors++;
      $display("FAIL clr_recover: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_stabilize;
    int budget;
    logic exp_p;
    cyc(1'b1, 1'b1, 1'b0);
    budget = 0;
    while (m_phase != PH_STAB && budget < 50) begin
      cyc(1'b0, 1'b1, 1'b0);
      budget++;
    end
    checks++;
    if (budget >= 50) begin
      errors++;
      $display("FAIL reach_stabilize: not reached in %0d cycles, want < 50", budget);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (pll_rst !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_stab_reset: pll_rst=%b sys_reset=%b ready=%b, want 1 1 0", pll_rst, sys_reset, ready);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      exp_p = (k <= RST);
      checks++;
      if (pll_rst !== exp_p || obs !== exp_vec()) begin
        errors++;
        $display("FAIL mid_stab_pulse edge+%0d: pll_rst=%b (want %b) outputs %b want %b", k, pll_rst, exp_p, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random;
    int seg;
    bit lvl;
    bit r, c;
    seg = 0;
    lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lvl = ~lvl;
        if (lvl) seg = $urandom_range(1, 25);
        else if ($urandom_range(0, 9) == 0) seg = $urandom_range(90, 130);
        else seg = $urandom_range(1, 8);
      end
      seg--;
      r = ($urandom_range(0, 499) == 0);
      c = ($urandom_range(0, 29) == 0);
      cyc(r, lvl, c);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL model_random edge %0d: got %b want %b", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_timeout();
    test_stabilize_toggle();
    test_clear_on_loss();
    test_reset_mid_stabilize();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
